// File: rtl/debug_pkg.sv
// Shared types for the debug tracer: FSM state encoding and trace-entry layout.
package debug_pkg;

    // 2'b11 is never entered; the tracer treats it as idle.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StArmed  = 2'b01,
        StHalted = 2'b10
    } state_e;

    localparam int unsigned DefDataW  = 64;
    localparam int unsigned DefRaddrW = 5;
    localparam int unsigned DefStampW = 32;

    // Field order of a trace entry, MSB first. The tracer packs its FIFO words
    // in this same order at whatever widths it is parametrised with.
    typedef struct packed {
        logic [DefStampW-1:0] stamp;
        logic [DefRaddrW-1:0] addr;
        logic [DefDataW-1:0]  data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with extra-bit pointers for full/empty and a synchronous flush.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if it pops too.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    // Pointer update: flush wins over any push or pop in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW + 1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/debug_tracer.sv
// Register-write tracer with watch channels, PC breakpoint/halt and a trace FIFO.
module debug_tracer
    import debug_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NUM_WATCH = 4,
    parameter int unsigned STAMP_W   = 32,
    localparam int unsigned IDX_W    = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_arm,
    input  logic               i_disarm,
    input  logic               i_resume,
    input  logic               i_cfg_we,
    input  logic [IDX_W-1:0]   i_cfg_idx,
    input  logic               i_cfg_en,
    input  logic [RADDR_W-1:0] i_cfg_addr,
    input  logic               i_bp_en,
    input  logic [DATA_W-1:0]  i_bp_pc,
    input  logic [DATA_W-1:0]  i_pc,
    input  logic               i_reg_wr,
    input  logic [RADDR_W-1:0] i_reg_waddr,
    input  logic [DATA_W-1:0]  i_reg_wdata,
    input  logic               i_rd_en,
    output logic               o_rd_valid,
    output logic [STAMP_W-1:0] o_rd_stamp,
    output logic [RADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0]  o_rd_data,
    output logic               o_halt,
    output logic               o_overflow,
    output logic [7:0]         o_drop_cnt,
    output logic [1:0]         o_state
);

    localparam int unsigned ENTRY_W = STAMP_W + RADDR_W + DATA_W;

    state_e               r_state;
    state_e               w_state;
    state_e               w_state_next;
    logic [NUM_WATCH-1:0] r_ch_en;
    logic [RADDR_W-1:0]   r_ch_addr [NUM_WATCH];
    logic [STAMP_W-1:0]   r_stamp;
    logic                 r_mask;
    logic [DATA_W-1:0]    r_mask_pc;
    logic                 r_overflow;
    logic [7:0]           r_drop_cnt;

    logic                 w_arm_go;
    logic                 w_resume_go;
    logic                 w_hit;
    logic                 w_bp_hit;
    logic                 w_capture;
    logic                 w_drop;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_head;

    // Decode the stored state so the unused encoding behaves as idle.
    always_comb begin
        unique case (r_state)
            StArmed:  w_state = StArmed;
            StHalted: w_state = StHalted;
            default:  w_state = StIdle;
        endcase
    end

    // Watch match: any enabled channel whose address equals the write address.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NUM_WATCH; k++) begin
            if (r_ch_en[k] && (r_ch_addr[k] == i_reg_waddr)) w_hit = 1'b1;
        end
    end

    // Breakpoint is suppressed while the pc still sits where resume was taken.
    assign w_bp_hit  = i_bp_en && (i_pc == i_bp_pc) && !(r_mask && (i_pc == r_mask_pc));
    assign w_capture = (w_state == StArmed) && i_reg_wr && (i_reg_waddr != '0) && w_hit;
    assign w_drop    = w_capture && w_fifo_full && !i_rd_en;
    assign w_entry   = {r_stamp, i_reg_waddr, i_reg_wdata};

    // Next state, priority disarm > resume > arm > breakpoint.
    always_comb begin
        w_state_next = w_state;
        w_arm_go     = 1'b0;
        w_resume_go  = 1'b0;
        if (i_disarm) begin
            w_state_next = StIdle;
        end else begin
            unique case (w_state)
                StHalted: begin
                    if (i_resume) begin
                        w_state_next = StArmed;
                        w_resume_go  = 1'b1;
                    end
                end
                StArmed: begin
                    if (w_bp_hit) w_state_next = StHalted;
                end
                default: begin
                    if (i_arm) begin
                        w_state_next = StArmed;
                        w_arm_go     = 1'b1;
                    end
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // Watch channel configuration; a same-cycle capture still sees the old values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ch_en <= '0;
            for (int k = 0; k < NUM_WATCH; k++) r_ch_addr[k] <= '0;
        end else if (i_cfg_we) begin
            for (int k = 0; k < NUM_WATCH; k++) begin
                if (i_cfg_idx == IDX_W'(k)) begin
                    r_ch_en[k]   <= i_cfg_en;
                    r_ch_addr[k] <= i_cfg_addr;
                end
            end
        end
    end

    // Cycle stamp: runs only while armed, restarts from zero on a fresh arm.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                   r_stamp <= '0;
        else if (w_arm_go)             r_stamp <= '0;
        else if (w_state == StArmed)   r_stamp <= r_stamp + STAMP_W'(1);
    end

    // Resume mask: remembers the pc at resume until the pc moves away.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mask    <= 1'b0;
            r_mask_pc <= '0;
        end else if (i_disarm) begin
            r_mask    <= 1'b0;
        end else if (w_resume_go) begin
            r_mask    <= 1'b1;
            r_mask_pc <= i_pc;
        end else if (i_pc != r_mask_pc) begin
            r_mask    <= 1'b0;
        end
    end

    // Overflow flag and saturating drop counter; cleared only by reset or a fresh arm.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_arm_go) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_arm_go),
        .i_push  (w_capture),
        .i_pop   (i_rd_en),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign o_rd_valid = !w_fifo_empty;
    assign o_rd_stamp = w_head[ENTRY_W-1 -: STAMP_W];
    assign o_rd_addr  = w_head[DATA_W +: RADDR_W];
    assign o_rd_data  = w_head[DATA_W-1:0];
    assign o_halt     = (w_state == StHalted);
    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;
    assign o_state    = w_state;

endmodule

// File: tb/tb_debug_tracer.sv
// Directed and randomized bench for debug_tracer against a queue-based reference model.
module tb_debug_tracer;

    localparam int DATA_W    = 64;
    localparam int RADDR_W   = 5;
    localparam int DEPTH     = 16;
    localparam int NUM_WATCH = 4;
    localparam int STAMP_W   = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               arm, disarm, resume;
    logic               cfg_we;
    logic [1:0]         cfg_idx;
    logic               cfg_en;
    logic [RADDR_W-1:0] cfg_addr;
    logic               bp_en;
    logic [DATA_W-1:0]  bp_pc;
    logic [DATA_W-1:0]  pc;
    logic               reg_wr;
    logic [RADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0]  reg_wdata;
    logic               rd_en;
    logic               rd_valid;
    logic [STAMP_W-1:0] rd_stamp;
    logic [RADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               halt;
    logic               overflow;
    logic [7:0]         drop_cnt;
    logic [1:0]         state;

    always #5 clk = ~clk;

    debug_tracer #(
        .DATA_W    (DATA_W),
        .RADDR_W   (RADDR_W),
        .DEPTH     (DEPTH),
        .NUM_WATCH (NUM_WATCH),
        .STAMP_W   (STAMP_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_arm       (arm),
        .i_disarm    (disarm),
        .i_resume    (resume),
        .i_cfg_we    (cfg_we),
        .i_cfg_idx   (cfg_idx),
        .i_cfg_en    (cfg_en),
        .i_cfg_addr  (cfg_addr),
        .i_bp_en     (bp_en),
        .i_bp_pc     (bp_pc),
        .i_pc        (pc),
        .i_reg_wr    (reg_wr),
        .i_reg_waddr (reg_waddr),
        .i_reg_wdata (reg_wdata),
        .i_rd_en     (rd_en),
        .o_rd_valid  (rd_valid),
        .o_rd_stamp  (rd_stamp),
        .o_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_halt      (halt),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt),
        .o_state     (state)
    );

    // Reference model: state as 0 idle / 1 armed / 2 halted, trace as a queue.
    typedef struct {
        logic [31:0] stamp;
        logic [4:0]  addr;
        logic [63:0] data;
    } ent_t;

    ent_t        m_q[$];
    int          m_state;
    logic [31:0] m_stamp;
    bit          m_ovf;
    int          m_drop;
    bit          m_en[NUM_WATCH];
    logic [4:0]  m_addr[NUM_WATCH];
    bit          m_mask;
    logic [63:0] m_mask_pc;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_stamp   = '0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_drop    = 0;
        m_mask    = 1'b0;
        m_mask_pc = '0;
        for (int k = 0; k < NUM_WATCH; k++) begin
            m_en[k]   = 1'b0;
            m_addr[k] = '0;
        end
    endtask

    task automatic model_edge();
        bit hit, cap, bp, arm_go, res_go, pop;
        int nxt;
        hit = 1'b0;
        for (int k = 0; k < NUM_WATCH; k++)
            if (m_en[k] && m_addr[k] == reg_waddr) hit = 1'b1;
        cap    = (m_state == 1) && reg_wr && (reg_waddr != 0) && hit;
        bp     = bp_en && (pc == bp_pc) && !(m_mask && pc == m_mask_pc);
        arm_go = !disarm && (m_state == 0) && arm;
        res_go = !disarm && (m_state == 2) && resume;
        nxt = m_state;
        if (disarm)                   nxt = 0;
        else if (res_go)              nxt = 1;
        else if (arm_go)              nxt = 1;
        else if (m_state == 1 && bp)  nxt = 2;
        if (disarm) m_mask = 1'b0;
        else if (res_go) begin
            m_mask    = 1'b1;
            m_mask_pc = pc;
        end else if (pc != m_mask_pc) m_mask = 1'b0;
        if (arm_go) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            pop = rd_en && (m_q.size() > 0);
            if (cap && m_q.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (cap) m_q.push_back('{m_stamp, reg_waddr, reg_wdata});
            end
        end
        if (arm_go) m_stamp = '0;
        else if (m_state == 1) m_stamp = m_stamp + 32'd1;
        if (cfg_we) begin
            m_en[cfg_idx]   = cfg_en;
            m_addr[cfg_idx] = cfg_addr;
        end
        m_state = nxt;
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("halt", 64'(halt), 64'(m_state == 2));
        chk("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("rd_stamp", 64'(rd_stamp), 64'(m_q[0].stamp));
            chk("rd_addr", 64'(rd_addr), 64'(m_q[0].addr));
            chk("rd_data", rd_data, m_q[0].data);
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic clear_pulses();
        arm    = 1'b0;
        disarm = 1'b0;
        resume = 1'b0;
        cfg_we = 1'b0;
        reg_wr = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        clear_pulses();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [4:0] a);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_en   = en;
        cfg_addr = a;
        tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic rd);
        reg_wr    = 1'b1;
        reg_waddr = a;
        reg_wdata = d;
        rd_en     = rd;
        tick();
    endtask

    task automatic rearm();
        disarm = 1'b1;
        tick();
        arm = 1'b1;
        tick();
    endtask

    initial begin
        clear_pulses();
        cfg_idx = '0; cfg_en = 1'b0; cfg_addr = '0;
        bp_en = 1'b0; bp_pc = '0; pc = '0;
        reg_waddr = '0; reg_wdata = '0;
        reset = 1'b1;
        model_reset();
        #3;
        check_all();
        #14 reset = 1'b0;

        // Watch x9 only; only the x9 write is captured.
        cfg(2'd0, 1'b1, 5'd9);
        arm = 1'b1;
        tick();
        wr(5'd9, 64'd5, 1'b0);
        chk("x9_valid", 64'(rd_valid), 64'd1);
        chk("x9_stamp", 64'(rd_stamp), 64'd0);
        chk("x9_addr", 64'(rd_addr), 64'd9);
        chk("x9_data", rd_data, 64'd5);
        wr(5'd20, 64'd7, 1'b0);
        rd_en = 1'b1;
        tick();
        chk("x9_single_entry", 64'(rd_valid), 64'd0);

        // Channel watching x0 never captures.
        cfg(2'd1, 1'b1, 5'd0);
        wr(5'd0, 64'hABCD, 1'b0);
        chk("x0_nocap", 64'(rd_valid), 64'd0);

        // Breakpoint, resume mask, re-halt after pc leaves and returns.
        bp_en = 1'b1;
        bp_pc = 64'h10;
        for (int i = 0; i < 4; i++) begin
            pc = 64'(4 * i);
            tick();
            chk("bp_walk_nohalt", 64'(halt), 64'd0);
        end
        pc = 64'h10;
        tick();
        chk("bp_halt", 64'(halt), 64'd1);
        resume = 1'b1;
        tick();
        chk("resume_armed", 64'(state), 64'd1);
        tick();
        tick();
        chk("resume_no_rehalt", 64'(halt), 64'd0);
        pc = 64'h14;
        tick();
        pc = 64'h10;
        tick();
        chk("bp_rehalt", 64'(halt), 64'd1);
        bp_en = 1'b0;

        // 18 watched writes into 16 entries: two drops.
        rearm();
        for (int i = 0; i < 18; i++) wr(5'd9, 64'(100 + i), 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_drop2", 64'(drop_cnt), 64'd2);
        chk("ovf_head", rd_data, 64'd100);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
        end
        chk("ovf_drained", 64'(rd_valid), 64'd0);

        // Full FIFO with simultaneous push and pop: no drop.
        rearm();
        chk("rearm_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) wr(5'd9, 64'(200 + i), 1'b0);
        wr(5'd9, 64'd999, 1'b1);
        chk("full_rw_nodrop", 64'(drop_cnt), 64'd0);
        chk("full_rw_head", rd_data, 64'd201);

        // Empty FIFO with simultaneous push and pop: push wins.
        rearm();
        wr(5'd9, 64'd42, 1'b1);
        chk("empty_rw_push", 64'(rd_valid), 64'd1);

        // Disarm keeps the queue; arm from idle flushes it and restarts the stamp.
        rearm();
        for (int i = 0; i < 3; i++) wr(5'd9, 64'(i + 1), 1'b0);
        disarm = 1'b1;
        tick();
        chk("disarm_keeps", 64'(rd_valid), 64'd1);
        arm = 1'b1;
        tick();
        chk("arm_flush", 64'(rd_valid), 64'd0);
        wr(5'd9, 64'd3, 1'b0);
        chk("arm_stamp0", 64'(rd_stamp), 64'd0);

        // Randomized traffic against the model.
        bp_pc = 64'h10;
        for (int i = 0; i < 1500; i++) begin
            arm       = ($urandom_range(0, 7) == 0);
            disarm    = ($urandom_range(0, 39) == 0);
            resume    = ($urandom_range(0, 5) == 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_en    = 1'($urandom);
            cfg_addr  = 5'($urandom_range(0, 7));
            bp_en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) pc = 64'(16 + 4 * $urandom_range(0, 2));
            reg_wr    = 1'($urandom);
            reg_waddr = 5'($urandom_range(0, 7));
            reg_wdata = {$urandom, $urandom};
            rd_en     = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Asynchronous reset while halted.
        disarm = 1'b1;
        tick();
        bp_en = 1'b1;
        bp_pc = 64'h10;
        pc    = 64'h20;
        arm   = 1'b1;
        tick();
        pc = 64'h10;
        tick();
        chk("pre_reset_halt", 64'(halt), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_halt_low", 64'(halt), 64'd0);
        model_reset();
        check_all();
        #2 reset = 1'b0;
        bp_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
